// File: rtl/countn_updn.sv
// countn_updn: parametrised synchronous up/down modulus counter with load.
// Define COUNT_SAT_EN to saturate at the bounds instead of wrapping.
module countn_updn #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
    localparam bit               FULL = (MODULUS == (2 ** WIDTH));

    logic             oor;
    logic [WIDTH-1:0] ld_val;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] q_step;
    logic             ovf_step;

    // With a full binary range no value can exceed MAXV, so skip the compares.
    generate
        if (FULL) begin : g_full
            assign oor    = 1'b0;
            assign ld_val = d;
        end else begin : g_part
            assign oor    = (q > MAXV);
            assign ld_val = (d > MAXV) ? MAXV : d;
        end
    endgenerate

    assign at_max  = (q == MAXV);
    assign at_zero = (q == '0);

    always_comb begin
        q_step   = q;
        ovf_step = 1'b0;
        if (up) begin
            if (at_max || oor) begin
`ifdef COUNT_SAT_EN
                q_step = MAXV;
`else
                q_step = '0;
`endif
                ovf_step = 1'b1;
            end else begin
                q_step = q + 1'b1;
            end
        end else begin
            if (oor) begin
                q_step   = MAXV;
                ovf_step = 1'b1;
            end else if (at_zero) begin
`ifdef COUNT_SAT_EN
                q_step = '0;
`else
                q_step = MAXV;
`endif
                ovf_step = 1'b1;
            end else begin
                q_step = q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q   <= RSTV;
            ovf <= 1'b0;
        end else if (ld) begin
            q   <= ld_val;
            ovf <= 1'b0;
        end else if (en) begin
            q   <= q_step;
            ovf <= ovf_step;
        end else begin
            ovf <= 1'b0;
        end
    end

    assign qb = ~q;
    assign tc = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_countn_updn.sv
// tb_countn_updn: scoreboard bench for countn_updn (WIDTH=4, MODULUS=10).
// Expected responses are queued by the stimulus and popped by a monitor.
module tb_countn_updn;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic       up  = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] d   = 4'd0;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
    logic       ovf;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       ovf;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    countn_updn #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
        .d(d), .q(q), .qb(qb), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic c, input logic e,
                        input logic u, input logic l, input logic [3:0] dv,
                        input logic [3:0] eq, input logic eo, input logic et);
        exp_t x;
        @(negedge clk);
        clr = c; en = e; up = u; ld = l; d = dv;
        x.name = nm; x.q = eq; x.ovf = eo; x.tc = et;
        sb.push_back(x);
    endtask

    task automatic cmp(input string nm, input logic [3:0] act,
                       input logic [3:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exv);
        end
    endtask

    // Monitor: the registered result appears just after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                cmp({x.name, ".q"}, q, x.q);
                cmp({x.name, ".qb"}, qb, ~x.q);
                cmp({x.name, ".ovf"}, {3'b0, ovf}, {3'b0, x.ovf});
                cmp({x.name, ".tc"}, {3'b0, tc}, {3'b0, x.tc});
            end
        end
    end

    initial begin
        int budget;
        //    name      clr en up ld d      q   ovf tc
        step("rst0",    0, 1, 1, 0, 4'd0,  3, 0, 0);
        step("rst1",    0, 1, 1, 0, 4'd0,  3, 0, 0);
        step("hold0",   1, 0, 1, 0, 4'd0,  3, 0, 0);
        step("hold1",   1, 0, 1, 0, 4'd0,  3, 0, 0);
        step("hold2",   1, 0, 1, 0, 4'd0,  3, 0, 0);
`ifndef COUNT_SAT_EN
        step("ld8",     1, 0, 1, 1, 4'd8,  8, 0, 0);
        step("up9",     1, 1, 1, 0, 4'd0,  9, 0, 1);
        step("upwrap",  1, 1, 1, 0, 4'd0,  0, 1, 0);
        step("up1",     1, 1, 1, 0, 4'd0,  1, 0, 0);
        step("ld1",     1, 0, 0, 1, 4'd1,  1, 0, 0);
        step("dn0",     1, 1, 0, 0, 4'd0,  0, 0, 1);
        step("dnwrap",  1, 1, 0, 0, 4'd0,  9, 1, 0);
        step("dn8",     1, 1, 0, 0, 4'd0,  8, 0, 0);
        step("ld9w",    1, 0, 1, 1, 4'd9,  9, 0, 0);
        step("wrapA",   1, 1, 1, 0, 4'd0,  0, 1, 0);
        step("holdA",   1, 0, 1, 0, 4'd0,  0, 0, 0);
        step("wrapB",   1, 1, 0, 0, 4'd0,  9, 1, 0);
        step("wrapC",   1, 1, 1, 0, 4'd0,  0, 1, 0);
`endif
        step("clamp",   1, 1, 1, 1, 4'd13, 9, 0, 1);
        step("clrld",   0, 1, 1, 1, 4'd5,  3, 0, 0);
        step("ld5",     1, 0, 1, 1, 4'd5,  5, 0, 0);
        step("flip6",   1, 1, 1, 0, 4'd0,  6, 0, 0);
        step("flip5",   1, 1, 0, 0, 4'd0,  5, 0, 0);
        step("flip6b",  1, 1, 1, 0, 4'd0,  6, 0, 0);
        step("flip5b",  1, 1, 0, 0, 4'd0,  5, 0, 0);
        step("ldmax",   1, 0, 1, 1, 4'd15, 9, 0, 0);
`ifdef COUNT_SAT_EN
        step("sat0",    1, 1, 1, 0, 4'd0,  9, 1, 1);
        step("sat1",    1, 1, 1, 0, 4'd0,  9, 1, 1);
        step("sat2",    1, 1, 1, 0, 4'd0,  9, 1, 1);
        step("satdn",   1, 1, 0, 0, 4'd0,  8, 0, 0);
        step("ld0",     1, 0, 0, 1, 4'd0,  0, 0, 0);
        step("satlo",   1, 1, 0, 0, 4'd0,  0, 1, 1);
        step("satup",   1, 1, 1, 0, 4'd0,  1, 0, 0);
`endif
        @(negedge clk);
        clr = 1; en = 0; ld = 0;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/countn_updn.md
Name: countn_updn

Overview:
- Parametrised synchronous up/down counter with width, modulus, load and enable.
- Successor to the fixed 4-bit ripple counter. All bits change on the same `clk` edge, so there are no ripple glitches.
- Adds direction control, parallel load, a programmable modulus, a terminal-count output and a wrap/overflow flag.
- Used as the general timebase/divider counter in the Counters library.

Parameters:
- WIDTH, 4, counter bit width; must be at least 1.
- MODULUS, 16, count range is 0..MODULUS-1; legal range is 2 to 2^WIDTH.
- RST_VAL, 0, value loaded on reset; must be less than MODULUS.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- ld  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- q  output  WIDTH  registered count.
- qb  output  WIDTH  bitwise complement of q, combinational from q.
- tc  output  1  terminal count, combinational.
- ovf  output  1  registered one-cycle wrap/limit flag.

Behaviour:
- Reset: if clr=0 at a rising edge of clk, then q=RST_VAL and ovf=0 on the next cycle.
  - clr has priority over ld and en.
  - There is no asynchronous path.
- Priority order at each edge: clr, then ld, then en, then hold.
- Load (clr=1, ld=1):
  - q gets d if d is at most MODULUS-1; otherwise q gets MODULUS-1 (clamped).
  - ovf=0.
  - en and up are ignored.
- Count up (clr=1, ld=0, en=1, up=1):
  - If q = MODULUS-1: q becomes 0 and ovf=1.
  - Otherwise: q becomes q+1 and ovf=0.
- Count down (clr=1, ld=0, en=1, up=0):
  - If q = 0: q becomes MODULUS-1 and ovf=1.
  - Otherwise: q becomes q-1 and ovf=0.
- Hold (clr=1, ld=0, en=0): q unchanged, ovf=0.
- ovf:
  - Asserts for exactly one cycle, the cycle after the wrapping edge.
  - Stays high on consecutive cycles only if consecutive edges wrap.
- tc = en AND ((up AND q = MODULUS-1) OR (NOT up AND q = 0)).
  - Combinational; indicates the next enabled edge wraps.
  - tc is 0 when en=0.
  - tc is not gated by ld or clr; the user qualifies it.
- Arithmetic:
  - Performed in WIDTH bits.
  - No intermediate value outside 0..MODULUS-1 ever appears on q.
  - When MODULUS = 2^WIDTH, wrap is the natural binary rollover.
- Direction change mid-count: takes effect on the next enabled edge; no extra latency.
- Reset mid-operation: any pending load or count is discarded; q=RST_VAL on the next cycle.
- Out-of-range state: if q somehow holds a value of MODULUS or more (e.g. X-propagation recovery), the next enabled up-step gives q=0 and ovf=1, and a down-step gives q=MODULUS-1 and ovf=1.
- Latency: one cycle from control sample to q; qb and tc follow q combinationally.

Optional Feature:
- Macro: COUNT_SAT_EN.
- Defined (saturating mode):
  - At a bound the count holds instead of wrapping.
  - Up with q=MODULUS-1 keeps q=MODULUS-1; down with q=0 keeps q=0.
  - ovf=1 for one cycle after each blocked step.
  - tc keeps the same equation.
- Undefined: wrap behaviour as specified above.
- Load, reset and hold behaviour are identical in both modes.

Test Plan:
- Reset, load, qb: WIDTH=4, MODULUS=10, RST_VAL=3.
  - Drive clr=0 for 2 edges with en=1 -> q=3, ovf=0, qb=4'b1100.
  - Release clr, hold en=0 for 3 edges -> q stays 3.
- Up-count wrap: load d=8, then en=1, up=1.
  - q goes 9 then 0; tc=1 while q=9.
  - ovf=1 only in the cycle with q=0, then q=1 with ovf=0.
- Down-count wrap: load d=1, then en=1, up=0.
  - q goes 0 then 9; tc=1 while q=0.
  - ovf=1 in the cycle with q=9.
- Load clamp and priority:
  - ld=1, d=13, en=1 -> q=9 (clamped), ovf=0.
  - clr=0 together with ld=1, d=5 -> q=3.
- Direction flip: at q=5, toggle up every edge with en=1 -> q goes 6, 5, 6, 5; ovf stays 0.
- COUNT_SAT_EN defined: load 9, en=1, up=1 for 3 edges.
  - q stays 9, with ovf=1 for each blocked step.
  - Then up=0 -> q=8, ovf=0.
